// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between N_CH producers, the arbitrating mux and one consumer.
// The slave modport is the arbiter's view; the master modport drives producers/consumer.
interface mux_rr_arbiter_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// N-channel valid/ready mux with an internal round-robin or fixed-priority arbiter
// feeding a one-entry output register.
module mux_rr_arbiter #(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);
    localparam int CH_W = $clog2(N_CH);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_last_grant;

    logic              w_free;
    logic              w_found;
    logic [N_CH-1:0]   w_grant;
    logic [CH_W-1:0]   w_grant_idx;
    logic [CH_W-1:0]   w_idx;

    assign w_free = !r_out_valid || bus.out_ready;

    // Search order starts just after the last winner (mode 0) or at channel 0 (mode 1).
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        if (w_free) begin
            for (int k = 0; k < N_CH; k++) begin
                if (PRIO_MODE == 1)
                    w_idx = CH_W'(k);
                else
                    w_idx = CH_W'((int'(r_last_grant) + 1 + k) % N_CH);
                if (!w_found && bus.in_valid[w_idx]) begin
                    w_found          = 1'b1;
                    w_grant[w_idx]   = 1'b1;
                    w_grant_idx      = w_idx;
                end
            end
        end
    end

    // Gated by reset so producers see no ready while the block is held in reset.
    assign bus.in_ready = rst_n ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_last_grant <= CH_W'(N_CH - 1);
        end else if (w_found) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= bus.in_data[w_grant_idx*WIDTH +: WIDTH];
            r_out_ch     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
        end else if (w_free) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with shared stimulus and
// checks both against a per-mode behavioural model of the output slot.
module tb_mux_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]   tb_valid = '0;
    logic [N*W-1:0] tb_data  = '0;
    logic           tb_ordy  = 1'b0;

    int vectors = 0;
    int errs    = 0;

    int m_ov[2];
    int m_od[2];
    int m_oc[2];
    int m_last[2];

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N_CH(N), .WIDTH(W)) if0 ();
    mux_rr_arbiter_if #(.N_CH(N), .WIDTH(W)) if1 ();

    assign if0.in_valid  = tb_valid;
    assign if0.in_data   = tb_data;
    assign if0.out_ready = tb_ordy;
    assign if1.in_valid  = tb_valid;
    assign if1.in_data   = tb_data;
    assign if1.out_ready = tb_ordy;

    mux_rr_arbiter #(.N_CH(N), .WIDTH(W), .PRIO_MODE(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_rr_arbiter #(.N_CH(N), .WIDTH(W), .PRIO_MODE(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ov[m] = 0; m_od[m] = 0; m_oc[m] = 0; m_last[m] = N - 1;
        end
    endfunction

    // Winner under the stated policy, or -1 when nothing may be granted.
    function automatic int model_grant(int m);
        int ch;
        if (!rst_n) return -1;
        if (m_ov[m] != 0 && !tb_ordy) return -1;
        for (int i = 1; i <= N; i++) begin
            ch = (m == 1) ? (i - 1) : ((m_last[m] + i) % N);
            if (tb_valid[ch]) return ch;
        end
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
        int g[2];
        logic [N-1:0] obs_rdy;
        logic obs_ov;
        logic [W-1:0] obs_od;
        logic [1:0] obs_oc;
        tb_valid = v; tb_data = d; tb_ordy = ordy;
        #1;
        for (int m = 0; m < 2; m++) begin
            g[m] = model_grant(m);
            obs_rdy = (m == 0) ? if0.in_ready  : if1.in_ready;
            obs_ov  = (m == 0) ? if0.out_valid : if1.out_valid;
            obs_od  = (m == 0) ? if0.out_data  : if1.out_data;
            obs_oc  = (m == 0) ? if0.out_ch    : if1.out_ch;
            chk(m == 0 ? "rr_in_ready" : "fp_in_ready", 32'(obs_rdy), (g[m] < 0) ? 32'd0 : (32'd1 << g[m]));
            chk(m == 0 ? "rr_out_valid" : "fp_out_valid", 32'(obs_ov), 32'(m_ov[m]));
            if (m_ov[m] != 0) begin
                chk(m == 0 ? "rr_out_data" : "fp_out_data", 32'(obs_od), 32'(m_od[m]));
                chk(m == 0 ? "rr_out_ch" : "fp_out_ch", 32'(obs_oc), 32'(m_oc[m]));
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_ov[m] = 0; m_od[m] = 0; m_oc[m] = 0; m_last[m] = N - 1;
            end else if (g[m] >= 0) begin
                m_ov[m] = 1; m_od[m] = int'(d[g[m]*W +: W]); m_oc[m] = g[m]; m_last[m] = g[m];
            end else if (m_ov[m] == 0 || ordy) begin
                m_ov[m] = 0;
            end
        end
        @(negedge clk);
    endtask

    logic [N*W-1:0] pat;
    logic [N*W-1:0] rnd;

    initial begin
        model_reset();
        pat = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset held with every channel requesting.
        @(negedge clk);
        cycle('1, pat, 1'b1);
        chk("rst_in_ready", 32'(if0.in_ready), 32'd0);
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_out_data", 32'(if0.out_data), 32'd0);
        chk("rst_out_ch", 32'(if0.out_ch), 32'd0);
        rst_n = 1'b1;

        // All valid: rotation in mode 0, channel 0 forever in mode 1.
        for (int k = 0; k < 8; k++) begin
            cycle('1, pat, 1'b1);
            chk("rr_seq_ch", 32'(if0.out_ch), 32'(k % N));
            chk("rr_seq_data", 32'(if0.out_data), 32'(pat[(k % N)*W +: W]));
            chk("rr_seq_valid", 32'(if0.out_valid), 32'd1);
            chk("fp_seq_ch", 32'(if1.out_ch), 32'd0);
        end

        // Back-pressure holding 0x5A from ch2.
        cycle(4'b0010, {8'h00, 8'h00, 8'h11, 8'h00}, 1'b1);
        cycle(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1010, {8'h33, 8'h00, 8'h44, 8'h00}, 1'b0);
            chk("bp_in_ready", 32'(if0.in_ready), 32'd0);
            chk("bp_data", 32'(if0.out_data), 32'h5A);
            chk("bp_ch", 32'(if0.out_ch), 32'd2);
        end
        tb_valid = 4'b1010; tb_ordy = 1'b1; #1;
        chk("bp_release_grant", 32'(if0.in_ready), 32'b1000);
        cycle(4'b1010, {8'h33, 8'h00, 8'h44, 8'h00}, 1'b1);
        chk("bp_release_ch", 32'(if0.out_ch), 32'd3);
        chk("bp_release_data", 32'(if0.out_data), 32'h33);

        // Sparse traffic across the wrap point.
        cycle(4'b0010, {8'h00, 8'h00, 8'h11, 8'h00}, 1'b1);
        chk("wrap_ch1", 32'(if0.out_ch), 32'd1);
        chk("wrap_d1", 32'(if0.out_data), 32'h11);
        cycle(4'b0001, {8'h00, 8'h00, 8'h00, 8'h22}, 1'b1);
        chk("wrap_ch0", 32'(if0.out_ch), 32'd0);
        chk("wrap_d0", 32'(if0.out_data), 32'h22);
        chk("wrap_valid", 32'(if0.out_valid), 32'd1);

        // Fixed priority starves ch3 until ch0 drops.
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1001, {8'h93, 8'h00, 8'h00, 8'h90}, 1'b1);
            chk("fp_starve_ch", 32'(if1.out_ch), 32'd0);
        end
        cycle(4'b1000, {8'h93, 8'h00, 8'h00, 8'h90}, 1'b1);
        chk("fp_ch3_ch", 32'(if1.out_ch), 32'd3);

        // Randomised traffic with occasional back-pressure.
        for (int k = 0; k < 300; k++) begin
            rnd = {$urandom, $urandom} & {N*W{1'b1}};
            cycle(4'($urandom_range(0, 15)), rnd, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges.
        cycle('1, pat, 1'b1);
        chk("arst_pre_valid", 32'(if0.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rr_valid", 32'(if0.out_valid), 32'd0);
        chk("arst_fp_valid", 32'(if1.out_valid), 32'd0);
        chk("arst_in_ready", 32'(if0.in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        cycle('1, pat, 1'b1);
        rst_n = 1'b1;
        cycle('1, pat, 1'b1);
        chk("arst_restart_ch", 32'(if0.out_ch), 32'd0);
        chk("arst_restart_valid", 32'(if0.out_valid), 32'd1);
        cycle('1, pat, 1'b1);
        chk("arst_next_ch", 32'(if0.out_ch), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Parametrised N-channel data multiplexer with valid/ready handshakes. The select is generated internally by a round-robin or fixed-priority arbiter, not driven externally.
- The winning channel's data is captured into a one-entry output register.
- Next-generation successor of the 2:1 combinational mux primitive. Used wherever several producers share one downstream consumer.

Parameters:
- N_CH, 4, number of input channels (>= 2).
- WIDTH, 8, data width per channel in bits.
- PRIO_MODE, 0, arbitration policy:
  - 0: round-robin.
  - 1: fixed priority, lowest index wins.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  N_CH  per-channel valid.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_CH  per-channel ready (one-hot or zero).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered data.
- out_ch  output  $clog2(N_CH)  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.

Behaviour:
- Reset (rst_n low, asynchronous assert; deassert synchronised by the environment):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last_grant=N_CH-1, so channel 0 has first priority.
  - in_ready=0 while rst_n is low.
- Reset mid-operation discards the held word. No transfer completes on the edge on which reset asserts.
- Slot free:
  - free = !out_valid || out_ready.
  - A registered word is released in the same cycle a new one is loaded. Full throughput is 1 word/cycle.
- Grant (combinational):
  - If free=0: grant=0.
  - PRIO_MODE=0: search channels starting at (last_grant+1) mod N_CH, wrapping upward. The first channel with in_valid=1 wins.
  - PRIO_MODE=1: the lowest index with in_valid=1 wins.
  - If no in_valid is set: grant=0.
- in_ready = grant (one-hot, at most one bit set). in_ready may depend combinationally on in_valid and out_ready. Sources must not make in_valid depend on in_ready.
- Transfer on channel i occurs on the rising edge where in_valid[i] && in_ready[i]. On that edge:
  - out_data <= in_data[i].
  - out_ch <= i.
  - out_valid <= 1.
  - last_grant <= i (updated in both modes; ignored in mode 1).
- Edge with free=1 and no grant: out_valid <= 0 if the held word was consumed, otherwise it is unchanged. out_data and out_ch hold their values.
- Back-pressure: out_valid=1 && out_ready=0 gives free=0. All in_ready=0. out_data and out_ch are stable until consumed.
- Latency: 1 cycle from input acceptance to out_valid.
- Fairness (mode 0): with all channels continuously valid and out_ready=1, grants follow 0,1,…,N_CH-1,0 with no channel skipped. Worst-case wait is N_CH-1 transfers.
- Wrap: with last_grant=N_CH-1 the search starts at channel 0.
- Mode 1 starvation of high-index channels is permitted and required behaviour.
- An input that drops in_valid before being granted is simply skipped. No state is kept for it.
- No combinational path from in_data to any output.

Test Plan:
- Reset check: hold rst_n=0 with all in_valid=1 → in_ready=0, out_valid=0, out_data=0, out_ch=0. Release reset with out_ready=1 → first grant is ch0; out_valid=1 and out_ch=0 one cycle later.
- Round-robin, mode 0, N_CH=4, WIDTH=8: data 0xA0/0xB1/0xC2/0xD3 on ch0–3, all valid, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3. out_data follows the channel. out_valid is continuously 1 after the first cycle.
- Back-pressure: hold word 0x5A from ch2, then set out_ready=0 for 3 cycles with ch1 and ch3 valid → in_ready=0, out_data=0x5A and out_ch=2 stable. On out_ready=1: ch3 is granted that cycle and appears next cycle (after last_grant=2).
- Sparse/wrap: last_grant=3, only ch1 valid (0x11), then only ch0 valid (0x22) → out_ch=1/0x11, then out_ch=0/0x22. No idle bubble while out_ready=1.
- Fixed priority, PRIO_MODE=1: ch0 and ch3 continuously valid for 4 cycles → out_ch=0 every cycle. Ch3 is granted only after ch0 deasserts.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 → out_valid drops immediately without a clock edge. After release, arbitration restarts at ch0.
